hazard_control_unit: RTL

- Pipeline hazard controller for the 16-bit, 8-register pipelined core.
- Drives the Stall/Flush controls consumed by the PC, IF/ID, ID/EX and EX/MEM pipeline registers.
- Detects load-use hazards and branch mispredictions, and sequences multi-cycle EX ops and data-memory wait states with an internal FSM and counter.

---
 rtl/hazard_control_unit.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/hazard_control_unit.sv
// Pipeline hazard controller: load-use, mispredict flush, multi-cycle EX and memory wait sequencing.
// Optional HAZARD_STATS_EN adds saturating Stall_Count / Flush_Count outputs.
module hazard_control_unit #(
  parameter int MUL_CYCLES = 4,
  parameter int REG_W      = 3
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             IDEX_MemRead,
  input  logic [REG_W-1:0] IDEX_Rt,
  input  logic [REG_W-1:0] IFID_Rs,
  input  logic [REG_W-1:0] IFID_Rt,
  input  logic             IFID_UsesRt,
  input  logic             Branch_Valid,
  input  logic             Branch_Taken_Pred,
  input  logic             Branch_Taken_Actual,
  input  logic             MulStart,
  input  logic             MemBusy,
  output logic             PC_Stall,
  output logic             PC_Redirect,
  output logic             IFID_Stall,
  output logic             IFID_Flush,
  output logic             IDEX_Stall,
  output logic             IDEX_Flush,
  output logic             EXMEM_Stall,
  output logic             EXMEM_Flush
`ifdef HAZARD_STATS_EN
  ,
  output logic [15:0]      Stall_Count,
  output logic [15:0]      Flush_Count
`endif
);

  localparam int CNT_W = (MUL_CYCLES > 2) ? $clog2(MUL_CYCLES - 1) : 1;

  typedef enum logic [1:0] {RUN, MUL_WAIT, MEM_WAIT} state_t;

  state_t           state_reg, state_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic             mispredict, load_use;
  logic             pc_stall, pc_redirect, ifid_stall, ifid_flush;
  logic             idex_stall, idex_flush, exmem_stall, exmem_flush;

  assign mispredict = Branch_Valid & (Branch_Taken_Pred != Branch_Taken_Actual);
  assign load_use   = IDEX_MemRead &
                      ((IDEX_Rt == IFID_Rs) | (IFID_UsesRt & (IDEX_Rt == IFID_Rt)));

  always_comb begin
    state_next  = state_reg;
    cnt_next    = cnt_reg;
    pc_stall    = 1'b0;
    pc_redirect = 1'b0;
    ifid_stall  = 1'b0;
    ifid_flush  = 1'b0;
    idex_stall  = 1'b0;
    idex_flush  = 1'b0;
    exmem_stall = 1'b0;
    exmem_flush = 1'b0;
    // Outputs are forced low for as long as reset is held, whatever the inputs.
    if (!RST) begin
      if (state_reg == MUL_WAIT) begin
        pc_stall    = 1'b1;
        ifid_stall  = 1'b1;
        idex_stall  = 1'b1;
        exmem_flush = 1'b1;
        if (cnt_reg == '0) state_next = RUN;
        else               cnt_next   = cnt_reg - 1'b1;
      end else if (state_reg == MEM_WAIT && MemBusy) begin
        pc_stall    = 1'b1;
        ifid_stall  = 1'b1;
        idex_stall  = 1'b1;
        exmem_stall = 1'b1;
      end else begin
        // RUN rules; also the exit cycle of MEM_WAIT once memory is ready.
        state_next = RUN;
        if (mispredict) begin
          pc_redirect = 1'b1;
          ifid_flush  = 1'b1;
          idex_flush  = 1'b1;
        end else if (MemBusy) begin
          pc_stall    = 1'b1;
          ifid_stall  = 1'b1;
          idex_stall  = 1'b1;
          exmem_stall = 1'b1;
          state_next  = MEM_WAIT;
        end else if (MulStart) begin
          pc_stall    = 1'b1;
          ifid_stall  = 1'b1;
          idex_stall  = 1'b1;
          exmem_flush = 1'b1;
          cnt_next    = CNT_W'(MUL_CYCLES - 2);
          state_next  = MUL_WAIT;
        end else if (load_use) begin
          pc_stall   = 1'b1;
          ifid_stall = 1'b1;
          idex_flush = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_reg <= RUN;
      cnt_reg   <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
    end
  end

  assign PC_Stall    = pc_stall;
  assign PC_Redirect = pc_redirect;
  assign IFID_Stall  = ifid_stall;
  assign IFID_Flush  = ifid_flush;
  assign IDEX_Stall  = idex_stall;
  assign IDEX_Flush  = idex_flush;
  assign EXMEM_Stall = exmem_stall;
  assign EXMEM_Flush = exmem_flush;

`ifdef HAZARD_STATS_EN
  logic [15:0] stall_count_reg, flush_count_reg;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      stall_count_reg <= '0;
      flush_count_reg <= '0;
    end else begin
      if (pc_stall && stall_count_reg != 16'hFFFF)
        stall_count_reg <= stall_count_reg + 16'd1;
      if (idex_flush && flush_count_reg != 16'hFFFF)
        flush_count_reg <= flush_count_reg + 16'd1;
    end
  end

  assign Stall_Count = stall_count_reg;
  assign Flush_Count = flush_count_reg;
`endif

endmodule
